i_decode: RTL
=============

# i_decode

Instruction-decode stage of the five-stage MIPS datapath, consuming the instruction word and next-PC produced by the fetch stage. Holds the 32 x 32 general register file, decodes the main control fields, sign-extends the immediate and registers everything into the ID/EX pipeline latch. Accepts the write-back port from the WB stage and a flush from branch resolution so that a taken branch squashes the instruction in decode.

## Interface

Parameters:
- WIDTH, 32, datapath and register width; only 32 is supported and verified.
- NREGS, 32, register-file depth; register index is 5 bits.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_in  in  32  instruction word from fetch.
- npc_in  in  32  PC+4 from fetch.
- flush  in  1  squash the instruction currently in decode (driven by PCSrc).
- wb_regwrite  in  1  write-back enable.
- wb_write_reg  in  5  write-back destination register.
- wb_write_data  in  32  write-back data.
- npc_out  out  32  latched npc_in.
- rd_data1  out  32  latched register[rs].
- rd_data2  out  32  latched register[rt].
- imm_out  out  32  latched sign-extended instr[15:0].
- rt_out  out  5  latched instr[20:16].
- rd_out  out  5  latched instr[15:11].
- ctl_wb  out  2  {RegWrite, MemtoReg}.
- ctl_m  out  3  {Branch, MemRead, MemWrite}.
- ctl_ex  out  4  {RegDst, ALUOp[1:0], ALUSrc}.

## Operation

- Decode on instr_in[31:26]:
  - 000000 R-type: ctl_wb=10, ctl_m=000, ctl_ex=1100.
  - 100011 lw: ctl_wb=11, ctl_m=010, ctl_ex=0001.
  - 101011 sw: ctl_wb=00, ctl_m=001, ctl_ex=0001.
  - 000100 beq: ctl_wb=00, ctl_m=100, ctl_ex=0010.
  - Any other opcode: all control zero (bubble); data fields still latched.
- Register file: 32 registers; register 0 always reads 0; writes to register 0 are ignored.
- Write: on the rising edge when wb_regwrite=1, reg[wb_write_reg] <= wb_write_data.
- Read: combinational from rs=instr_in[25:21] and rt=instr_in[20:16].
  - Write-through: if wb_regwrite=1 and wb_write_reg equals rs (or rt) and is non-zero, the read returns wb_write_data in the same cycle.
- imm_out = {{16{instr_in[15]}}, instr_in[15:0]}.
- ID/EX latch: all outputs register every rising edge; there is no stall input.
- Flush: when flush=1 at the edge, ctl_wb, ctl_m and ctl_ex load 0; data outputs load normally. Flush has priority over decode.
- The register-file write proceeds regardless of flush.

## Timing

- Latency: exactly 1 cycle from instr_in/npc_in to the outputs.
- Write-back takes effect at the same edge; a same-cycle read of that register sees the new value via write-through.
- Reset (asynchronous, active-high), applied immediately at any time including mid-operation:
  - All 32 registers clear to 0.
  - All outputs clear to 0; ctl all-zero is a NOP.
  - A write-back coincident with reset is dropped.
- After rst deasserts, the first rising edge latches normally.
- Simultaneous flush and wb_regwrite: the bubble is inserted and the write still occurs.

## Test plan

- Reset: assert rst mid-stream -> all outputs 0 immediately; a subsequent read of r5 returns 0.
- Write then read: write r3=0x0000_00AA, next cycle add $1,$3,$3 (0x00630820) -> rd_data1=rd_data2=0xAA, rd_out=1, ctl_wb=10, ctl_ex=1100.
- Write-through and r0: in the same cycle, write r8=0x1234_5678 and decode lw $9,-4($8) (0x8D09FFFC) -> rd_data1=0x12345678, imm_out=0xFFFF_FFFC, ctl_wb=11, ctl_m=010. Write r0=5 -> reading r0 returns 0.
- Flush: decode beq (0x10220003) with flush=1 -> ctl outputs all zero; npc_out and imm_out=0x0000_0003 still latched.
- Unknown opcode 0x3C010001 (lui) -> all control zero; rt_out=1.
- Back-to-back stream of 8 mixed instructions -> each output appears exactly one cycle after its input, with no drops.

Source files
------------

// File: rtl/i_decode.sv
// MIPS ID stage: 32x32 register file with write-through, main control decode, ID/EX latch.
// One-cycle latency from instr_in/npc_in to outputs; no stall input, so the latch loads every cycle.
module i_decode #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_in,
  input  logic [WIDTH-1:0] npc_in,
  input  logic             flush,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_write_reg,
  input  logic [WIDTH-1:0] wb_write_data,
  output logic [WIDTH-1:0] npc_out,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  output logic [WIDTH-1:0] imm_out,
  output logic [4:0]       rt_out,
  output logic [4:0]       rd_out,
  output logic [1:0]       ctl_wb,
  output logic [2:0]       ctl_m,
  output logic [3:0]       ctl_ex
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  logic [WIDTH-1:0] regs [NREGS];
  logic [4:0]       rs, rt;
  logic [WIDTH-1:0] rs_val, rt_val, imm_ext;
  logic [1:0]       dec_wb;
  logic [2:0]       dec_m;
  logic [3:0]       dec_ex;

  assign rs      = instr_in[25:21];
  assign rt      = instr_in[20:16];
  assign imm_ext = {{(WIDTH-16){instr_in[15]}}, instr_in[15:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_regwrite && wb_write_reg != 5'd0) begin
      regs[wb_write_reg] <= wb_write_data;
    end
  end

  // Write-through lets a WB in this cycle reach the instruction being decoded now.
  always_comb begin
    rs_val = regs[rs];
    rt_val = regs[rt];
    if (wb_regwrite && wb_write_reg == rs) rs_val = wb_write_data;
    if (wb_regwrite && wb_write_reg == rt) rt_val = wb_write_data;
    if (rs == 5'd0) rs_val = '0;
    if (rt == 5'd0) rt_val = '0;
  end

  always_comb begin
    dec_wb = 2'b00;
    dec_m  = 3'b000;
    dec_ex = 4'b0000;
    case (instr_in[31:26])
      OP_RTYPE: begin dec_wb = 2'b10; dec_m = 3'b000; dec_ex = 4'b1100; end
      OP_LW:    begin dec_wb = 2'b11; dec_m = 3'b010; dec_ex = 4'b0001; end
      OP_SW:    begin dec_wb = 2'b00; dec_m = 3'b001; dec_ex = 4'b0001; end
      OP_BEQ:   begin dec_wb = 2'b00; dec_m = 3'b100; dec_ex = 4'b0010; end
      default:  begin dec_wb = 2'b00; dec_m = 3'b000; dec_ex = 4'b0000; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      npc_out  <= '0;
      rd_data1 <= '0;
      rd_data2 <= '0;
      imm_out  <= '0;
      rt_out   <= '0;
      rd_out   <= '0;
      ctl_wb   <= '0;
      ctl_m    <= '0;
      ctl_ex   <= '0;
    end else begin
      npc_out  <= npc_in;
      rd_data1 <= rs_val;
      rd_data2 <= rt_val;
      imm_out  <= imm_ext;
      rt_out   <= instr_in[20:16];
      rd_out   <= instr_in[15:11];
      ctl_wb   <= flush ? 2'b00   : dec_wb;
      ctl_m    <= flush ? 3'b000  : dec_m;
      ctl_ex   <= flush ? 4'b0000 : dec_ex;
    end
  end

endmodule
